// File: rtl/alu_muldiv_pkg.sv
// Shared op codes, decode helpers and handshake FSM states for the ALU/MUL/DIV pipe.
package alu_muldiv_pkg;

  localparam logic [4:0] OP_ADD    = 5'h00;
  localparam logic [4:0] OP_XOR    = 5'h01;
  localparam logic [4:0] OP_OR     = 5'h02;
  localparam logic [4:0] OP_AND    = 5'h03;
  localparam logic [4:0] OP_SLL    = 5'h04;
  localparam logic [4:0] OP_SRL    = 5'h05;
  localparam logic [4:0] OP_SRA    = 5'h06;
  localparam logic [4:0] OP_BEQ    = 5'h08;
  localparam logic [4:0] OP_BNE    = 5'h09;
  localparam logic [4:0] OP_BLT    = 5'h0A;
  localparam logic [4:0] OP_BGE    = 5'h0B;
  localparam logic [4:0] OP_SET    = 5'h0C;
  localparam logic [4:0] OP_MUL    = 5'h10;
  localparam logic [4:0] OP_MULH   = 5'h11;
  localparam logic [4:0] OP_MULHSU = 5'h12;
  localparam logic [4:0] OP_MULHU  = 5'h13;
  localparam logic [4:0] OP_DIV    = 5'h14;
  localparam logic [4:0] OP_DIVU   = 5'h15;
  localparam logic [4:0] OP_REM    = 5'h16;
  localparam logic [4:0] OP_REMU   = 5'h17;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  function automatic logic is_mop(input logic [4:0] op);
    return op[4:3] == 2'b10;
  endfunction

  function automatic logic is_div(input logic [4:0] op);
    return op[4:2] == 3'b101;
  endfunction

  function automatic logic is_signed_a(input logic [4:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input logic [4:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/alu_muldiv_pipe_muldiv.sv
// Iterative multiply/divide: one shift-add or restoring-divide step per cycle
// over unsigned magnitudes, with sign fixup folded into the final step.
module muldiv_iter
  import alu_muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            start,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN) + 1;

  logic [2*XLEN-1:0] acc_q, acc_d, acc_step, prod;
  logic [XLEN-1:0]   md_q, md_d, ma, mb, div_val;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              div_q, div_d, hi_q, hi_d, neg_q, neg_d;
  logic              sa, sb;
  logic [XLEN:0]     mul_sum, div_rem, div_diff;

  always_comb begin
    sa = is_signed_a(op) && a[XLEN-1];
    sb = is_signed_b(op) && b[XLEN-1];
    ma = sa ? -a : a;
    mb = sb ? -b : b;

    // mul: acc = {partial product, remaining multiplier bits}
    // div: acc = {partial remainder, dividend bits shifting into quotient}
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, md_q} : '0);
    div_rem  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff = div_rem - {1'b0, md_q};
    if (div_q) begin
      acc_step = div_diff[XLEN] ? {div_rem[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      acc_step = {mul_sum, acc_q[XLEN-1:1]};
    end

    prod    = neg_q ? -acc_step : acc_step;
    div_val = hi_q ? acc_step[2*XLEN-1:XLEN] : acc_step[XLEN-1:0];
    if (div_q) begin
      result = neg_q ? -div_val : div_val;
    end else begin
      result = hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    end

    acc_d = acc_q;
    md_d  = md_q;
    cnt_d = cnt_q;
    div_d = div_q;
    hi_d  = hi_q;
    neg_d = neg_q;
    if (start) begin
      div_d = is_div(op);
      hi_d  = is_div(op) ? op[1] : (op != OP_MUL);
      neg_d = (is_div(op) && op[1]) ? sa : (sa ^ sb);
      md_d  = is_div(op) ? mb : ma;
      acc_d = {{XLEN{1'b0}}, (is_div(op) ? ma : mb)};
      cnt_d = CW'(XLEN);
    end else if (cnt_q != '0) begin
      acc_d = acc_step;
      cnt_d = cnt_q - CW'(1);
    end
    if (flush) begin
      cnt_d = '0;
    end

    done = (cnt_q == CW'(1));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
      md_q  <= '0;
      cnt_q <= '0;
      div_q <= 1'b0;
      hi_q  <= 1'b0;
      neg_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      md_q  <= md_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
      hi_q  <= hi_d;
      neg_q <= neg_d;
    end
  end

endmodule

// File: rtl/alu_muldiv_pipe.sv
// XLEN-wide ALU with iterative MUL/DIV behind valid/ready handshakes;
// base ops and divide special cases finish in one cycle, M ops in XLEN.
module alu_muldiv_pipe
  import alu_muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic            sub,
  input  logic            sign,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zf,
  output logic            of,
  output logic            cf,
  output logic            branch
);

  localparam int unsigned SHW = $clog2(XLEN);

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zf_q, zf_d, of_q, of_d, cf_q, cf_d, br_q, br_d;

  logic            accept, mdu_start, mdu_done;
  logic [XLEN-1:0] mdu_result;
  logic [XLEN-1:0] b_eff, sum, alu_res, special_res;
  logic            carry, add_zf, add_of, lt, br;
  logic [SHW-1:0]  shamt;
  logic            div_zero, div_ovf, special;

  muldiv_iter #(
    .XLEN (XLEN)
  ) u_muldiv (
    .clock   (clock),
    .reset_n (reset_n),
    .flush   (flush),
    .start   (mdu_start),
    .op      (op),
    .a       (a),
    .b       (b),
    .done    (mdu_done),
    .result  (mdu_result)
  );

  always_comb begin
    b_eff        = sub ? ~b : b;
    {carry, sum} = {1'b0, a} + {1'b0, b_eff} + {{XLEN{1'b0}}, sub};
    add_zf       = (sum == '0);
    add_of       = (a[XLEN-1] == b_eff[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
    lt           = sign ? (add_of ^ sum[XLEN-1]) : ~carry;
    shamt        = b[SHW-1:0];

    alu_res = sum;
    br      = 1'b0;
    case (op)
      OP_XOR:  alu_res = a ^ b;
      OP_OR:   alu_res = a | b;
      OP_AND:  alu_res = a & b;
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = $signed(a) >>> shamt;
      OP_BEQ:  begin alu_res = {{(XLEN-1){1'b0}}, lt}; br = add_zf; end
      OP_BNE:  begin alu_res = {{(XLEN-1){1'b0}}, lt}; br = ~add_zf; end
      OP_BLT:  begin alu_res = {{(XLEN-1){1'b0}}, lt}; br = lt; end
      OP_BGE:  begin alu_res = {{(XLEN-1){1'b0}}, lt}; br = ~lt; end
      OP_SET:  alu_res = {{(XLEN-1){1'b0}}, lt};
      default: alu_res = sum;
    endcase

    div_zero = (b == '0);
    div_ovf  = is_signed_a(op) && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    special  = is_div(op) && (div_zero || div_ovf);
    if (div_zero) begin
      special_res = op[1] ? a : '1;
    end else begin
      special_res = op[1] ? '0 : a;
    end
  end

  assign in_ready  = ~flush && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zf        = zf_q;
  assign of        = of_q;
  assign cf        = cf_q;
  assign branch    = br_q;

  // A new accept in DONE overrides the DONE->IDLE move, giving back-to-back issue.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zf_d      = zf_q;
    of_d      = of_q;
    cf_d      = cf_q;
    br_d      = br_q;
    mdu_start = 1'b0;
    if (flush) begin
      state_d = IDLE;
    end else begin
      if ((state_q == BUSY) && mdu_done) begin
        state_d  = DONE;
        result_d = mdu_result;
        {zf_d, of_d, cf_d, br_d} = '0;
      end
      if ((state_q == DONE) && out_ready) begin
        state_d = IDLE;
      end
      if (accept) begin
        if (!is_mop(op)) begin
          state_d  = DONE;
          result_d = alu_res;
          zf_d     = add_zf;
          of_d     = add_of;
          cf_d     = carry;
          br_d     = br;
        end else if (special) begin
          state_d  = DONE;
          result_d = special_res;
          {zf_d, of_d, cf_d, br_d} = '0;
        end else begin
          state_d   = BUSY;
          mdu_start = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      zf_q     <= 1'b0;
      of_q     <= 1'b0;
      cf_q     <= 1'b0;
      br_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zf_q     <= zf_d;
      of_q     <= of_d;
      cf_q     <= cf_d;
      br_q     <= br_d;
    end
  end

endmodule

// File: tb/tb_alu_muldiv_pipe.sv
// Randomized bench for alu_muldiv_pipe with an arithmetic reference model and per-cycle output checks.
module tb_alu_muldiv_pipe;

  logic        clock, reset_n, flush, in_valid, in_ready, sub, sign;
  logic [4:0]  op;
  logic [31:0] a, b, result;
  logic        out_valid, out_ready, zf, of, cf, branch;
  logic        rdy_force, rdy_val;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  typedef struct {
    logic [31:0] res;
    logic        zf, of, cf, br;
    int          lat;
    int          cyc;
  } exp_t;

  exp_t q[$];

  alu_muldiv_pipe #(.XLEN(32)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .sub(sub), .sign(sign), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zf(zf), .of(of), .cf(cf), .branch(branch)
  );

  initial clock = 0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired at t=%0t", name, $time);
  endtask

  // Lat counts clock edges after the accept edge until out_valid rises.
  function automatic exp_t model(input logic [4:0] o, input logic s, input logic sg,
                                 input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    logic [31:0] yy;
    longint ts, p;
    longint unsigned us, up;
    int ix, iy;
    logic lt;
    e = '{res: '0, zf: 0, of: 0, cf: 0, br: 0, lat: 0, cyc: 0};
    ix = x;
    iy = y;
    if (o >= 5'h10 && o <= 5'h17) begin
      e.lat = 32;
      case (o)
        5'h10: begin up = 64'(x) * 64'(y); e.res = up[31:0]; end
        5'h11: begin p = longint'($signed(x)) * longint'($signed(y)); e.res = p[63:32]; end
        5'h12: begin p = longint'($signed(x)) * longint'(64'(y)); e.res = p[63:32]; end
        5'h13: begin up = 64'(x) * 64'(y); e.res = up[63:32]; end
        5'h14, 5'h16: begin
          if (y == 0) begin
            e.res = (o == 5'h14) ? 32'hFFFFFFFF : x; e.lat = 0;
          end else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin
            e.res = (o == 5'h14) ? x : 32'h0; e.lat = 0;
          end else begin
            e.res = (o == 5'h14) ? ix / iy : ix % iy;
          end
        end
        default: begin
          if (y == 0) begin
            e.res = (o == 5'h15) ? 32'hFFFFFFFF : x; e.lat = 0;
          end else begin
            e.res = (o == 5'h15) ? x / y : x % y;
          end
        end
      endcase
    end else begin
      yy = s ? ~y : y;
      ts = longint'($signed(x)) + longint'($signed(yy)) + longint'(s);
      us = 64'(x) + 64'(yy) + 64'(s);
      e.zf = (us[31:0] == 0);
      e.cf = us[32];
      e.of = (ts != longint'(int'(ts)));
      lt = sg ? (ts < 0) : (us < 64'h1_0000_0000);
      case (o)
        5'h01: e.res = x ^ y;
        5'h02: e.res = x | y;
        5'h03: e.res = x & y;
        5'h04: e.res = x << y[4:0];
        5'h05: e.res = x >> y[4:0];
        5'h06: e.res = $signed(x) >>> y[4:0];
        5'h08: begin e.res = 32'(lt); e.br = e.zf; end
        5'h09: begin e.res = 32'(lt); e.br = !e.zf; end
        5'h0A: begin e.res = 32'(lt); e.br = lt; end
        5'h0B: begin e.res = 32'(lt); e.br = !lt; end
        5'h0C: e.res = 32'(lt);
        default: e.res = us[31:0];
      endcase
    end
    return e;
  endfunction

  // Hand-computed pins on the model, then per-cycle comparison against the queue.
  initial begin
    exp_t m, e;
    logic due;
    m = model(5'h00, 0, 0, 32'h7FFFFFFF, 32'h1);
    chk("pin_add_res", m.res, 32'h80000000); chk("pin_add_of", 32'(m.of), 1);
    chk("pin_add_cf", 32'(m.cf), 0);         chk("pin_add_zf", 32'(m.zf), 0);
    m = model(5'h0C, 1, 1, 32'hFFFFFFFF, 32'h1); chk("pin_set_signed", m.res, 1);
    m = model(5'h0C, 1, 0, 32'hFFFFFFFF, 32'h1); chk("pin_set_unsigned", m.res, 0);
    m = model(5'h08, 1, 0, 32'h1234, 32'h1234);
    chk("pin_beq_br", 32'(m.br), 1); chk("pin_beq_zf", 32'(m.zf), 1);
    m = model(5'h0B, 1, 1, 32'hFFFFFFFB, 32'h3); chk("pin_bge_br", 32'(m.br), 0);
    m = model(5'h06, 0, 0, 32'h80000000, 32'h4); chk("pin_sra", m.res, 32'hF8000000);
    m = model(5'h11, 0, 0, 32'hFFFFFFFE, 32'h3);
    chk("pin_mulh", m.res, 32'hFFFFFFFF); chk("pin_mulh_lat", m.lat, 32);
    m = model(5'h10, 0, 0, 32'hFFFFFFFE, 32'h3); chk("pin_mul", m.res, 32'hFFFFFFFA);
    m = model(5'h13, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF); chk("pin_mulhu", m.res, 32'hFFFFFFFE);
    m = model(5'h14, 0, 0, 32'h7, 32'h0);
    chk("pin_div0", m.res, 32'hFFFFFFFF); chk("pin_div0_lat", m.lat, 0);
    m = model(5'h16, 0, 0, 32'h80000000, 32'hFFFFFFFF);
    chk("pin_rem_ovf", m.res, 32'h0); chk("pin_rem_ovf_lat", m.lat, 0);
    m = model(5'h14, 0, 0, 32'hFFFFFFF9, 32'h2); chk("pin_div_neg", m.res, 32'hFFFFFFFD);
    m = model(5'h16, 0, 0, 32'hFFFFFFF9, 32'h2); chk("pin_rem_neg", m.res, 32'hFFFFFFFF);
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        q.delete();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_result", result, 0);
        chk("rst_flags", 32'({zf, of, cf, branch}), 0);
      end else begin
        if (flush) chk("flush_in_ready", 32'(in_ready), 0);
        if (q.size() == 0) begin
          chk("idle_out_valid", 32'(out_valid), 0);
          if (!flush) chk("idle_in_ready", 32'(in_ready), 1);
        end else begin
          e = q[0];
          due = (cyc >= e.cyc + 1 + e.lat);
          chk("out_valid_timing", 32'(out_valid), 32'(due));
          if (!flush) chk("in_ready", 32'(in_ready), 32'(due && out_ready));
          if (due) begin
            chk("result", result, e.res);
            chk("flags_zf_of_cf_br", 32'({zf, of, cf, branch}), 32'({e.zf, e.of, e.cf, e.br}));
            if (out_ready) void'(q.pop_front());
          end
        end
        if (flush) begin
          q.delete();
        end else if (in_valid && in_ready) begin
          e = model(op, sub, sign, a, b);
          e.cyc = cyc;
          q.push_back(e);
        end
      end
    end
  end

  initial begin
    out_ready = 0;
    forever begin
      @(posedge clock);
      #2;
      out_ready = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic issue(input logic [4:0] o, input logic s, input logic sg,
                       input logic [31:0] x, input logic [31:0] y);
    int n;
    op = o; sub = s; sign = sg; a = x; b = y; in_valid = 1;
    n = 0;
    while (1) begin
      @(negedge clock);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        timeout_fail("issue_accept");
        break;
      end
    end
    @(posedge clock);
    #1;
    in_valid = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      cycles(1);
      n++;
    end
    if (q.size() != 0) timeout_fail("drain");
  endtask

  initial begin
    #800000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  o;
    logic [31:0] x, y;
    reset_n = 0; flush = 0; in_valid = 0; op = 0; sub = 0; sign = 0; a = 0; b = 0;
    rdy_force = 1; rdy_val = 1;
    cycles(3);
    reset_n = 1;
    cycles(1);

    issue(5'h00, 0, 0, 32'h7FFFFFFF, 32'h1);
    issue(5'h0C, 1, 1, 32'hFFFFFFFF, 32'h1);
    issue(5'h0C, 1, 0, 32'hFFFFFFFF, 32'h1);
    issue(5'h08, 1, 0, 32'h1234, 32'h1234);
    issue(5'h0B, 1, 1, 32'hFFFFFFFB, 32'h3);
    issue(5'h06, 0, 0, 32'h80000000, 32'h4);
    issue(5'h11, 0, 0, 32'hFFFFFFFE, 32'h3);
    issue(5'h10, 0, 0, 32'hFFFFFFFE, 32'h3);
    issue(5'h13, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    issue(5'h14, 0, 0, 32'h7, 32'h0);
    issue(5'h16, 0, 0, 32'h80000000, 32'hFFFFFFFF);
    issue(5'h14, 0, 0, 32'hFFFFFFF9, 32'h2);
    issue(5'h16, 0, 0, 32'hFFFFFFF9, 32'h2);
    drain();

    // Backpressure: result held while out_ready is low, then handoff on the same edge.
    rdy_val = 0;
    issue(5'h00, 0, 0, 32'h11, 32'h22);
    cycles(6);
    rdy_val = 1;
    issue(5'h01, 0, 0, 32'hA5A5A5A5, 32'h0F0F0F0F);
    drain();

    // Flush on the 10th cycle of a DIVU, then a quick ADD.
    issue(5'h15, 0, 0, 32'hDEADBEEF, 32'h13);
    cycles(9);
    flush = 1;
    cycles(1);
    flush = 0;
    cycles(40);
    issue(5'h00, 0, 0, 32'h2, 32'h3);
    drain();

    // Reset in the middle of a DIV.
    issue(5'h14, 0, 0, 32'h12345678, 32'h7);
    cycles(5);
    reset_n = 0;
    cycles(2);
    reset_n = 1;
    cycles(40);
    issue(5'h00, 0, 0, 32'h2, 32'h3);
    drain();

    rdy_force = 0;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0:       o = 5'($urandom);
        1:       o = 5'($urandom_range(0, 12));
        default: o = 5'h10 + 5'($urandom_range(0, 7));
      endcase
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 0;
        1: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
        2: y = $urandom_range(0, 3);
        3: x = y;
        default: ;
      endcase
      issue(o, 1'($urandom), 1'($urandom), x, y);
      if ($urandom_range(0, 19) == 0) begin
        cycles($urandom_range(0, 35));
        in_valid = 1'($urandom);
        flush = 1;
        cycles(1);
        flush = 0;
        in_valid = 0;
      end else begin
        cycles($urandom_range(0, 2));
      end
    end
    rdy_force = 1;
    rdy_val = 1;
    drain();
    cycles(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
